// File: rtl/dma64_rsp_pkg.sv
// dma64_rsp_pkg: shared state type, size code, widths and request-legality helper for dma64_mem_responder
package dma64_rsp_pkg;
  localparam int DATA_W = 64;
  localparam int IDX_W = 32;
  localparam int SIZE_W = 3;
  localparam logic [SIZE_W-1:0] DMA_SIZE_64 = 3'b011;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
  function automatic logic req_bad(
    input logic [SIZE_W-1:0] size,
    input logic [IDX_W-1:0]  len,
    input logic [IDX_W-1:0]  index,
    input int                max_len,
    input int                mem_words
  );
    return size != DMA_SIZE_64 || len > 32'(max_len) || index >= 32'(mem_words);
  endfunction
endpackage

// File: rtl/dma64_rsp_mem.sv
// dma64_rsp_mem: MEM_WORDS x 64 storage with one synchronous write port and one combinational read port
module dma64_rsp_mem
  import dma64_rsp_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_WORDS];
  // write port; storage has no reset so contents survive a responder reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/dma64_mem_responder.sv
// dma64_mem_responder: 64-bit DMA memory responder serving one read or write burst at a time; DMA64_RSP_CHECK_EN enables the sticky err flag
module dma64_mem_responder
  import dma64_rsp_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int MAX_LEN   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_read_ctrl_valid,
  output logic              dma_read_ctrl_ready,
  input  logic [IDX_W-1:0]  dma_read_ctrl_data_index,
  input  logic [IDX_W-1:0]  dma_read_ctrl_data_length,
  input  logic [SIZE_W-1:0] dma_read_ctrl_data_size,
  output logic              dma_read_chnl_valid,
  input  logic              dma_read_chnl_ready,
  output logic [DATA_W-1:0] dma_read_chnl_data,
  input  logic              dma_write_ctrl_valid,
  output logic              dma_write_ctrl_ready,
  input  logic [IDX_W-1:0]  dma_write_ctrl_data_index,
  input  logic [IDX_W-1:0]  dma_write_ctrl_data_length,
  input  logic [SIZE_W-1:0] dma_write_ctrl_data_size,
  input  logic              dma_write_chnl_valid,
  output logic              dma_write_chnl_ready,
  input  logic [DATA_W-1:0] dma_write_chnl_data,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(MEM_WORDS);
  state_e            state;
  logic [IDX_W-1:0]  idx, len, cnt;
  logic [SIZE_W-1:0] size;
  logic              prefer_rd;
  logic              idle, rd_hs, wr_hs, rd_beat, wr_beat, last;
  logic [IDX_W-1:0]  req_idx, req_len;
  logic [SIZE_W-1:0] req_size;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] mem_q;
  logic              unused_ok;
  assign idle = state == ST_IDLE;
  assign dma_read_ctrl_ready  = rst && idle && !(dma_write_ctrl_valid && !prefer_rd);
  assign dma_write_ctrl_ready = rst && idle && !(dma_read_ctrl_valid && prefer_rd);
  assign rd_hs = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign wr_hs = dma_write_ctrl_valid && dma_write_ctrl_ready;
  assign req_idx  = rd_hs ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
  assign req_len  = rd_hs ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
  assign req_size = rd_hs ? dma_read_ctrl_data_size   : dma_write_ctrl_data_size;
  assign addr = AW'(idx + cnt);
  assign dma_read_chnl_valid  = state == ST_READ;
  assign dma_read_chnl_data   = dma_read_chnl_valid ? mem_q : '0;
  assign dma_write_chnl_ready = state == ST_WRITE;
  assign rd_beat = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_beat = dma_write_chnl_ready && dma_write_chnl_valid;
  assign last = cnt == len - 32'd1;
  assign busy = !idle;
  assign unused_ok = ^{size, 32'(MAX_LEN)};
  // request capture, round-robin update, beat counting and state transitions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len       <= '0;
      cnt       <= '0;
      size      <= '0;
      prefer_rd <= 1'b1;
    end else if (rd_hs || wr_hs) begin
      state     <= req_len == '0 ? ST_IDLE : (rd_hs ? ST_READ : ST_WRITE);
      idx       <= req_idx;
      len       <= req_len;
      size      <= req_size;
      cnt       <= '0;
      prefer_rd <= wr_hs;
    end else if (rd_beat || wr_beat) begin
      cnt   <= cnt + 32'd1;
      state <= last ? ST_IDLE : state;
    end
  end
`ifdef DMA64_RSP_CHECK_EN
  // sticky flag raised by any accepted request with illegal size, length or start index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else if ((rd_hs || wr_hs) && req_bad(req_size, req_len, req_idx, MAX_LEN, MEM_WORDS)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
  dma64_rsp_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk  (clk),
    .we   (wr_beat),
    .addr (addr),
    .wdata(dma_write_chnl_data),
    .rdata(mem_q)
  );
endmodule

// File: tb/tb_dma64_mem_responder.sv
// tb_dma64_mem_responder: directed self-checking bench for dma64_mem_responder
module tb_dma64_mem_responder;
  localparam int MW = 1024;
`ifdef DMA64_RSP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_read_ctrl_valid = 1'b0;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index = '0;
  logic [31:0] dma_read_ctrl_data_length = '0;
  logic [2:0]  dma_read_ctrl_data_size = 3'b011;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready = 1'b0;
  logic [63:0] dma_read_chnl_data;
  logic        dma_write_ctrl_valid = 1'b0;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index = '0;
  logic [31:0] dma_write_ctrl_data_length = '0;
  logic [2:0]  dma_write_ctrl_data_size = 3'b011;
  logic        dma_write_chnl_valid = 1'b0;
  logic        dma_write_chnl_ready;
  logic [63:0] dma_write_chnl_data = '0;
  logic        busy;
  logic        err;
  int checks = 0;
  int errors = 0;
  logic [63:0] wq[$];
  logic [63:0] rq[$];

  always #5 clk = ~clk;

  dma64_mem_responder #(.MEM_WORDS(MW), .MAX_LEN(65535)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .dma_read_ctrl_valid       (dma_read_ctrl_valid),
    .dma_read_ctrl_ready       (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
    .dma_read_chnl_valid       (dma_read_chnl_valid),
    .dma_read_chnl_ready       (dma_read_chnl_ready),
    .dma_read_chnl_data        (dma_read_chnl_data),
    .dma_write_ctrl_valid      (dma_write_ctrl_valid),
    .dma_write_ctrl_ready      (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size  (dma_write_ctrl_data_size),
    .dma_write_chnl_valid      (dma_write_chnl_valid),
    .dma_write_chnl_ready      (dma_write_chnl_ready),
    .dma_write_chnl_data       (dma_write_chnl_data),
    .busy                      (busy),
    .err                       (err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz, output bit ok);
    dma_read_ctrl_valid = 1'b1;
    dma_read_ctrl_data_index = idx;
    dma_read_ctrl_data_length = len;
    dma_read_ctrl_data_size = sz;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (dma_read_ctrl_ready) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    if (ok) step;
    dma_read_ctrl_valid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] idx, input logic [31:0] len, output bit ok);
    dma_write_ctrl_valid = 1'b1;
    dma_write_ctrl_data_index = idx;
    dma_write_ctrl_data_length = len;
    dma_write_ctrl_data_size = 3'b011;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (dma_write_ctrl_ready) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    if (ok) step;
    dma_write_ctrl_valid = 1'b0;
  endtask

  task automatic write_beats(output bit ok);
    bit got;
    ok = 1'b1;
    foreach (wq[k]) begin
      dma_write_chnl_valid = 1'b1;
      dma_write_chnl_data = wq[k];
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        #1;
        if (dma_write_chnl_ready) begin
          got = 1'b1;
          break;
        end
        step;
      end
      if (!got) ok = 1'b0;
      step;
    end
    dma_write_chnl_valid = 1'b0;
  endtask

  task automatic read_beats(input int n);
    rq.delete();
    dma_read_chnl_ready = 1'b1;
    for (int i = 0; i < n + 50 && rq.size() < n; i++) begin
      #1;
      if (dma_read_chnl_valid) rq.push_back(dma_read_chnl_data);
      step;
    end
    dma_read_chnl_ready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] idx, input logic [31:0] len, input string name);
    bit ok1, ok2;
    send_write(idx, len, ok1);
    write_beats(ok2);
    checks++;
    if ({ok1, ok2} !== 2'b11) begin
      errors++;
      $display("FAIL %s_write_handshake: got %b expected 11", name, {ok1, ok2});
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({dma_read_ctrl_ready, dma_write_ctrl_ready, dma_read_chnl_valid, dma_write_chnl_ready, busy, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {dma_read_ctrl_ready, dma_write_ctrl_ready, dma_read_chnl_valid, dma_write_chnl_ready, busy, err});
    end
    checks++;
    if (dma_read_chnl_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 0", dma_read_chnl_data);
    end
    step;
    step;
    rst = 1'b1;
    #1;
    checks++;
    if ({dma_read_ctrl_ready, dma_write_ctrl_ready, busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 110", {dma_read_ctrl_ready, dma_write_ctrl_ready, busy});
    end
  endtask

  task automatic test_arbiter;
    dma_read_ctrl_valid = 1'b1;
    dma_read_ctrl_data_index = 32'd300;
    dma_read_ctrl_data_length = 32'd1;
    dma_read_ctrl_data_size = 3'b011;
    dma_write_ctrl_valid = 1'b1;
    dma_write_ctrl_data_index = 32'd301;
    dma_write_ctrl_data_length = 32'd1;
    dma_write_ctrl_data_size = 3'b011;
    dma_read_chnl_ready = 1'b1;
    #1;
    checks++;
    if ({dma_read_ctrl_ready, dma_write_ctrl_ready} !== 2'b10) begin
      errors++;
      $display("FAIL arb_first_grant: got %b expected 10", {dma_read_ctrl_ready, dma_write_ctrl_ready});
    end
    step;
    dma_read_ctrl_valid = 1'b0;
    #1;
    checks++;
    if ({busy, dma_read_chnl_valid, dma_write_ctrl_ready} !== 3'b110) begin
      errors++;
      $display("FAIL arb_read_active: got %b expected 110", {busy, dma_read_chnl_valid, dma_write_ctrl_ready});
    end
    step;
    dma_read_chnl_ready = 1'b0;
    #1;
    checks++;
    if ({busy, dma_write_ctrl_ready} !== 2'b01) begin
      errors++;
      $display("FAIL arb_write_next: got %b expected 01", {busy, dma_write_ctrl_ready});
    end
    step;
    dma_write_ctrl_valid = 1'b0;
    #1;
    checks++;
    if (dma_write_chnl_ready !== 1'b1) begin
      errors++;
      $display("FAIL arb_write_chnl_ready: got %b expected 1", dma_write_chnl_ready);
    end
    wq = '{64'hABCD_0000_0000_0301};
    begin
      bit ok;
      write_beats(ok);
    end
    begin
      bit ok;
      send_read(32'd301, 32'd1, 3'b011, ok);
    end
    read_beats(1);
    checks++;
    if (rq.size() != 1 || rq[0] !== 64'hABCD_0000_0000_0301) begin
      errors++;
      $display("FAIL arb_write_data: got %h (n=%0d) expected abcd000000000301", rq.size() > 0 ? rq[0] : 64'h0, rq.size());
    end
  endtask

  task automatic test_basic;
    bit ok;
    wq = '{64'h7777_7777_0000_0007};
    do_write(32'd7, 32'd1, "basic_g");
    wq = '{64'hAAAA_0000_1111_0004, 64'hBBBB_0000_2222_0005, 64'hCCCC_0000_3333_0006};
    do_write(32'd4, 32'd3, "basic");
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after_write: got %b expected 0", busy);
    end
    dma_write_chnl_valid = 1'b1;
    dma_write_chnl_data = 64'hDEAD_BEEF_DEAD_BEEF;
    dma_read_chnl_ready = 1'b1;
    #1;
    checks++;
    if ({dma_write_chnl_ready, dma_read_chnl_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_chnl_ignored: got %b expected 00", {dma_write_chnl_ready, dma_read_chnl_valid});
    end
    step;
    step;
    step;
    dma_write_chnl_valid = 1'b0;
    dma_read_chnl_ready = 1'b0;
    send_read(32'd4, 32'd3, 3'b011, ok);
    #1;
    checks++;
    if ({ok, dma_read_chnl_valid} !== 2'b11) begin
      errors++;
      $display("FAIL basic_rd_valid_latency: got %b expected 11", {ok, dma_read_chnl_valid});
    end
    read_beats(3);
    checks++;
    if (rq.size() != 3) begin
      errors++;
      $display("FAIL basic_rd_count: got %0d expected 3", rq.size());
    end
    for (int k = 0; k < 3 && k < rq.size(); k++) begin
      checks++;
      if (rq[k] !== wq[k]) begin
        errors++;
        $display("FAIL basic_rd_beat%0d: got %h expected %h", k, rq[k], wq[k]);
      end
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after_read: got %b expected 0", busy);
    end
    send_read(32'd7, 32'd1, 3'b011, ok);
    read_beats(1);
    checks++;
    if (rq.size() != 1 || rq[0] !== 64'h7777_7777_0000_0007) begin
      errors++;
      $display("FAIL idle_write_no_effect: got %h expected 7777777700000007", rq.size() > 0 ? rq[0] : 64'h0);
    end
  endtask

  task automatic test_len0;
    bit ok;
    send_read(32'd50, 32'd0, 3'b011, ok);
    #1;
    checks++;
    if ({ok, busy, dma_read_chnl_valid, dma_read_ctrl_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL len0_read: got %b expected 1001", {ok, busy, dma_read_chnl_valid, dma_read_ctrl_ready});
    end
    send_write(32'd50, 32'd0, ok);
    #1;
    checks++;
    if ({ok, busy, dma_write_chnl_ready} !== 3'b100) begin
      errors++;
      $display("FAIL len0_write: got %b expected 100", {ok, busy, dma_write_chnl_ready});
    end
  endtask

  task automatic test_stall;
    bit ok, stalled;
    logic [63:0] held;
    wq = '{64'h1000_0000_0000_0020, 64'h2000_0000_0000_0021, 64'h3000_0000_0000_0022, 64'h4000_0000_0000_0023};
    do_write(32'd20, 32'd4, "stall");
    send_read(32'd20, 32'd4, 3'b011, ok);
    rq.delete();
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && rq.size() < 4; c++) begin
      dma_read_chnl_ready = (c % 3 == 0);
      #1;
      if (dma_read_chnl_valid) begin
        if (stalled) begin
          checks++;
          if (dma_read_chnl_data !== held) begin
            errors++;
            $display("FAIL stall_hold_c%0d: got %h expected %h", c, dma_read_chnl_data, held);
          end
        end
        if (dma_read_chnl_ready) rq.push_back(dma_read_chnl_data);
        stalled = !dma_read_chnl_ready;
        held = dma_read_chnl_data;
      end
      step;
    end
    dma_read_chnl_ready = 1'b1;
    #1;
    checks++;
    if ({dma_read_chnl_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL stall_no_extra_beat: got %b expected 00", {dma_read_chnl_valid, busy});
    end
    dma_read_chnl_ready = 1'b0;
    checks++;
    if (rq.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 4", rq.size());
    end
    for (int k = 0; k < 4 && k < rq.size(); k++) begin
      checks++;
      if (rq[k] !== wq[k]) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h expected %h", k, rq[k], wq[k]);
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    wq = '{64'hD0D0_D0D0_0000_03FF, 64'hE0E0_E0E0_0000_0000};
    do_write(MW - 1, 32'd2, "wrap");
    send_read(MW - 1, 32'd2, 3'b011, ok);
    read_beats(2);
    checks++;
    if (rq.size() != 2 || rq[0] !== wq[0] || rq[1] !== wq[1]) begin
      errors++;
      $display("FAIL wrap_read: got %h %h (n=%0d) expected %h %h",
               rq.size() > 0 ? rq[0] : 64'h0, rq.size() > 1 ? rq[1] : 64'h0, rq.size(), wq[0], wq[1]);
    end
    send_read(32'd0, 32'd1, 3'b011, ok);
    read_beats(1);
    checks++;
    if (rq.size() != 1 || rq[0] !== 64'hE0E0_E0E0_0000_0000) begin
      errors++;
      $display("FAIL wrap_word0: got %h expected e0e0e0e000000000", rq.size() > 0 ? rq[0] : 64'h0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [63:0] vals [8];
    wq.delete();
    for (int k = 0; k < 8; k++) begin
      vals[k] = 64'h5500_0000_0000_0040 + 64'(k);
      wq.push_back(vals[k]);
    end
    do_write(32'd40, 32'd8, "rstmid");
    send_read(32'd40, 32'd8, 3'b011, ok);
    dma_read_chnl_ready = 1'b1;
    step;
    step;
    #1;
    checks++;
    if ({dma_read_chnl_valid, dma_read_chnl_data} !== {1'b1, vals[2]}) begin
      errors++;
      $display("FAIL rstmid_beat2: got %b %h expected 1 %h", dma_read_chnl_valid, dma_read_chnl_data, vals[2]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({dma_read_ctrl_ready, dma_write_ctrl_ready, dma_read_chnl_valid, dma_write_chnl_ready, busy, err} !== 6'b0
        || dma_read_chnl_data !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b %h expected 000000 0",
               {dma_read_ctrl_ready, dma_write_ctrl_ready, dma_read_chnl_valid, dma_write_chnl_ready, busy, err},
               dma_read_chnl_data);
    end
    dma_read_chnl_ready = 1'b0;
    step;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, dma_read_ctrl_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_idle: got %b expected 01", {busy, dma_read_ctrl_ready});
    end
    send_read(32'd41, 32'd3, 3'b011, ok);
    read_beats(3);
    checks++;
    if (rq.size() != 3 || rq[0] !== vals[1] || rq[1] !== vals[2] || rq[2] !== vals[3]) begin
      errors++;
      $display("FAIL rstmid_next_read: got %h %h %h (n=%0d) expected %h %h %h",
               rq.size() > 0 ? rq[0] : 64'h0, rq.size() > 1 ? rq[1] : 64'h0, rq.size() > 2 ? rq[2] : 64'h0,
               rq.size(), vals[1], vals[2], vals[3]);
    end
  endtask

  task automatic test_err;
    bit ok;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b expected 0", err);
    end
    send_read(32'd60, 32'd1, 3'b010, ok);
    #1;
    checks++;
    if ({ok, err, dma_read_chnl_valid} !== {1'b1, ERR_EXP, 1'b1}) begin
      errors++;
      $display("FAIL err_bad_size: got %b expected %b", {ok, err, dma_read_chnl_valid}, {1'b1, ERR_EXP, 1'b1});
    end
    read_beats(1);
    send_read(32'd60, 32'd1, 3'b011, ok);
    read_beats(1);
    #1;
    checks++;
    if (err !== ERR_EXP) begin
      errors++;
      $display("FAIL err_sticky: got %b expected %b", err, ERR_EXP);
    end
    rst = 1'b0;
    step;
    rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_reset: got %b expected 0", err);
    end
  endtask

  initial begin
    test_reset;
    test_arbiter;
    test_basic;
    test_len0;
    test_stall;
    test_wrap;
    test_reset_mid;
    test_err;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma64_mem_responder.md
DMA64_MEM_RESPONDER -- requirements
Module: dma64_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, memory depth in 64-bit words (power of two).
REQ-002 Parameter MAX_LEN, default 65535, largest legal beat count per request.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 dma_read_ctrl_valid  input  1  read request valid.
REQ-006 dma_read_ctrl_ready  output  1  read request accepted.
REQ-007 dma_read_ctrl_data_index / _length  input  32 each  start word index / beat count.
REQ-008 dma_read_ctrl_data_size  input  3  beat size code; 3'b011 = 64-bit.
REQ-009 dma_read_chnl_valid  output  1  read beat valid.
REQ-010 dma_read_chnl_ready  input  1  accelerator accepts beat.
REQ-011 dma_read_chnl_data  output  64  read beat.
REQ-012 dma_write_ctrl_valid / _ready  input / output  1 each  write request handshake.
REQ-013 dma_write_ctrl_data_index / _length / _size  input  32/32/3  as read side.
REQ-014 dma_write_chnl_valid / _ready  input / output  1 each  write beat handshake.
REQ-015 dma_write_chnl_data  input  64  write beat.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  sticky request-error flag.

Function
REQ-018 FSM states IDLE, READ, WRITE; one transfer in flight at a time.
REQ-019 Both ctrl readies high only in IDLE; handshake = valid&&ready on a rising edge.
REQ-020 Simultaneous read and write requests in IDLE: round-robin, first grant after reset to read, then alternating.
REQ-021 Only the granted side sees ready high that cycle; loser's valid stays pending.
REQ-022 Handshake latches index, length, size; beat counter cleared.
REQ-023 Length 0: no beats; FSM returns to IDLE the cycle after the handshake.
REQ-024 READ: dma_read_chnl_valid rises the cycle after the ctrl handshake; beat i = mem[(index+i) mod MEM_WORDS].
REQ-025 READ: data and valid stable while valid&&!ready; with ready held high, beats back-to-back, one per cycle.
REQ-026 WRITE: dma_write_chnl_ready high from the cycle after the ctrl handshake until the last beat; each accepted beat i writes mem[(index+i) mod MEM_WORDS].
REQ-027 Address arithmetic modulo MEM_WORDS; wrap-around is silent and legal.
REQ-028 After the last beat handshake, FSM enters IDLE next cycle; ctrl ready may be high that cycle.
REQ-029 Chnl valid/ready high outside the owning state: ignored, no memory effect.

Reset
REQ-030 rst low forces IDLE, all handshake outputs 0, read data 0, busy 0, err 0, arbiter to read-first, asynchronously.
REQ-031 Reset mid-transfer abandons it; memory contents are not cleared and beats already written persist.

Configuration
REQ-032 Macro DMA64_RSP_CHECK_EN defined: err set and held when an accepted request has size != 3'b011, length > MAX_LEN, or index >= MEM_WORDS; the transfer still proceeds per REQ-024..027.
REQ-033 Macro undefined: err tied 0, no checking logic; port list unchanged.

Structure
REQ-034 Package dma64_rsp_pkg holds the state enum, DMA_SIZE_64 = 3'b011, and data/index width constants.
REQ-035 Sub-module dma64_rsp_mem: MEM_WORDS x 64 array, one write port, one combinational read port; no reset on storage.

Verification
REQ-036 Write index 4, length 3, beats A,B,C; read index 4, length 3 -> read beats A,B,C in order; busy low afterwards.
REQ-037 Read length 4 with read_chnl_ready toggling 1,0,0,1,... -> data held stable during stalls, exactly 4 beats, no duplicates.
REQ-038 Read and write ctrl valid together from reset -> read granted first, write granted the first IDLE cycle after the read completes.
REQ-039 Write index MEM_WORDS-1, length 2 -> words MEM_WORDS-1 and 0 written; read back matches.
REQ-040 rst pulsed low during beat 2 of a length-8 read -> outputs 0 immediately, IDLE after release, next request served correctly.
REQ-041 With DMA64_RSP_CHECK_EN, read size 3'b010 -> err rises after handshake and stays high until reset; without macro err stays 0.
